// File: rtl/vending_ctrl_fsm.sv
// vending_ctrl_fsm: drink vending controller.
// Captures one drink selection from the raw pushbuttons, accumulates coin
// credit against the drink cost, returns change (or a refund on cancel),
// then times the serving phase in whole seconds.
// Drink i costs COST_TABLE[i*AMT_W +: AMT_W] and serves for
// SERVE_TABLE[i*TIME_W +: TIME_W] seconds. With the default tables drink 0
// costs 4 and serves 8 s, drink 1 costs 3 / 6 s, drink 2 costs 2 / 5 s and
// drink 3 costs 1 / 3 s.
// Optional feature macro: VEND_TIMEOUT_EN -- when defined, a purchase left in
// PAY for TIMEOUT_S seconds without a coin is refunded as if cancelled.
module vending_ctrl_fsm #(
  parameter int NUM_DRINKS    = 4,
  parameter int AMT_W         = 8,
  parameter int TIME_W        = 5,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter logic [NUM_DRINKS*AMT_W-1:0]  COST_TABLE  = {8'd1, 8'd2, 8'd3, 8'd4},
  parameter logic [NUM_DRINKS*TIME_W-1:0] SERVE_TABLE = {5'd3, 5'd5, 5'd6, 5'd8},
  parameter int TIMEOUT_S     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DRINKS-1:0] sel_n,
  input  logic                  coin_valid,
  input  logic [AMT_W-1:0]      coin_val,
  input  logic                  cancel,
  output logic [NUM_DRINKS-1:0] selected,
  output logic [AMT_W-1:0]      credit,
  output logic [AMT_W-1:0]      cost,
  output logic [AMT_W-1:0]      change,
  output logic                  change_valid,
  output logic                  serving,
  output logic [TIME_W-1:0]     time_left,
  output logic                  done,
  output logic                  coin_reject,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PAY    = 3'd1,
    S_SERVE  = 3'd2,
    S_DONE   = 3'd3,
    S_REFUND = 3'd4
  } state_e;

  localparam int IDX_W = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1;
  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

`ifdef VEND_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);
`endif

  // Saturating credit accumulation: never wraps past the all-ones value.
  function automatic logic [AMT_W-1:0] sat_add(input logic [AMT_W-1:0] a,
                                               input logic [AMT_W-1:0] b);
    logic [AMT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AMT_W] ? {AMT_W{1'b1}} : s[AMT_W-1:0];
  endfunction

  // Button synchroniser and edge-detect history
  logic [NUM_DRINKS-1:0] sync1_q;
  logic [NUM_DRINKS-1:0] sync2_q;
  logic [NUM_DRINKS-1:0] prev_q;

  // FSM state and registered outputs
  state_e                state_q;
  logic [IDX_W-1:0]      drink_q;
  logic [NUM_DRINKS-1:0] selected_q;
  logic [AMT_W-1:0]      credit_q;
  logic [AMT_W-1:0]      cost_q;
  logic [AMT_W-1:0]      change_q;
  logic                  change_valid_q;
  logic                  serving_q;
  logic [TIME_W-1:0]     time_left_q;
  logic                  done_q;
  logic                  coin_reject_q;
  logic [PRE_W-1:0]      presc_q;
`ifdef VEND_TIMEOUT_EN
  logic [IDLE_W-1:0]     idle_q;
`endif

  // Combinational helpers
  logic [NUM_DRINKS-1:0] press_d;
  logic                  pick_vld_d;
  logic [IDX_W-1:0]      pick_idx_d;
  logic [AMT_W-1:0]      pick_cost_d;
  logic [TIME_W-1:0]     serve_time_d;
  logic [AMT_W-1:0]      coin_amt_d;
  logic [AMT_W-1:0]      credit_sum_d;
  logic                  paid_d;
  logic                  tick_d;
  logic                  serve_end_d;
  logic                  timeout_d;

  // Two-flop synchroniser on the raw buttons plus one history stage for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sel_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A press is a high-to-low transition of the synchronised active-low button
  assign press_d = prev_q & ~sync2_q;

  // Priority pick: scanning downward lets the lowest pressed index win
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    for (int i = NUM_DRINKS - 1; i >= 0; i--) begin
      if (press_d[i]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = IDX_W'(i);
      end
    end
  end

  assign pick_cost_d  = COST_TABLE[int'(pick_idx_d)*AMT_W +: AMT_W];
  assign serve_time_d = SERVE_TABLE[int'(drink_q)*TIME_W +: TIME_W];
  assign coin_amt_d   = coin_valid ? coin_val : '0;
  // Credit including a coin arriving this cycle; used for refunds and for the
  // payment-complete cycle so a late coin is returned in the change.
  assign credit_sum_d = sat_add(credit_q, coin_amt_d);
  assign paid_d       = (credit_q >= cost_q);
  assign tick_d       = (presc_q == PRE_LAST);
  // Serving ends on the tick that would take time_left from 1 to 0, or at once
  // for a zero serve time, so serving lasts exactly N seconds of clocks.
  assign serve_end_d  = (time_left_q == '0) ||
                        (tick_d && (time_left_q == TIME_W'(1)));

`ifdef VEND_TIMEOUT_EN
  assign timeout_d = tick_d && (idle_q == IDLE_LAST);
`else
  assign timeout_d = 1'b0;
`endif

  // Payment/serving FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      drink_q        <= '0;
      selected_q     <= '0;
      credit_q       <= '0;
      cost_q         <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      serving_q      <= 1'b0;
      time_left_q    <= '0;
      done_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      presc_q        <= '0;
`ifdef VEND_TIMEOUT_EN
      idle_q         <= '0;
`endif
    end else begin
      change_valid_q <= 1'b0;
      done_q         <= 1'b0;
      coin_reject_q  <= coin_valid && (state_q != S_PAY);

      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            selected_q <= NUM_DRINKS'(1) << pick_idx_d;
            cost_q     <= pick_cost_d;
            credit_q   <= '0;
            drink_q    <= pick_idx_d;
            presc_q    <= '0;
`ifdef VEND_TIMEOUT_EN
            idle_q     <= '0;
`endif
            state_q    <= S_PAY;
          end
        end

        S_PAY: begin
          if (cancel || (timeout_d && !paid_d && !coin_valid)) begin
            // Refund everything held, including a coin dropped in alongside cancel
            change_q       <= credit_sum_d;
            change_valid_q <= 1'b1;
            selected_q     <= '0;
            credit_q       <= '0;
            cost_q         <= '0;
            state_q        <= S_REFUND;
          end else if (paid_d) begin
            credit_q       <= credit_sum_d;
            change_q       <= credit_sum_d - cost_q;
            change_valid_q <= 1'b1;
            serving_q      <= 1'b1;
            time_left_q    <= serve_time_d;
            presc_q        <= '0;
            state_q        <= S_SERVE;
          end else if (coin_valid) begin
            credit_q <= credit_sum_d;
            presc_q  <= '0;
`ifdef VEND_TIMEOUT_EN
            idle_q   <= '0;
`endif
          end else begin
`ifdef VEND_TIMEOUT_EN
            if (tick_d) begin
              presc_q <= '0;
              idle_q  <= idle_q + IDLE_W'(1);
            end else begin
              presc_q <= presc_q + PRE_W'(1);
            end
`endif
          end
        end

        S_SERVE: begin
          if (serve_end_d) begin
            serving_q   <= 1'b0;
            time_left_q <= '0;
            done_q      <= 1'b1;
            selected_q  <= '0;
            credit_q    <= '0;
            cost_q      <= '0;
            state_q     <= S_DONE;
          end else if (tick_d) begin
            presc_q     <= '0;
            time_left_q <= time_left_q - TIME_W'(1);
          end else begin
            presc_q <= presc_q + PRE_W'(1);
          end
        end

        S_DONE:   state_q <= S_IDLE;
        S_REFUND: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign selected     = selected_q;
  assign credit       = credit_q;
  assign cost         = cost_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign serving      = serving_q;
  assign time_left    = time_left_q;
  assign done         = done_q;
  assign coin_reject  = coin_reject_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_vending_ctrl_fsm.sv
// Testbench for vending_ctrl_fsm with a one-second tick of 4 clocks.
// Change/refund values are queued when the paying stimulus is driven and
// compared whenever the DUT pulses change_valid.
module tb_vending_ctrl_fsm;
  localparam int ND = 4;
  localparam int AW = 8;
  localparam int TW = 5;
  localparam int TPS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] sel_n;
  logic          coin_valid;
  logic [AW-1:0] coin_val;
  logic          cancel;
  logic [ND-1:0] selected;
  logic [AW-1:0] credit;
  logic [AW-1:0] cost;
  logic [AW-1:0] change;
  logic          change_valid;
  logic          serving;
  logic [TW-1:0] time_left;
  logic          done;
  logic          coin_reject;
  logic [2:0]    state_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  vending_ctrl_fsm #(
    .NUM_DRINKS(ND), .AMT_W(AW), .TIME_W(TW), .TICKS_PER_SEC(TPS),
    .COST_TABLE({8'd1, 8'd2, 8'd3, 8'd4}),
    .SERVE_TABLE({5'd3, 5'd5, 5'd6, 5'd8}),
    .TIMEOUT_S(10)
  ) dut (
    .clk(clk), .rst(rst), .sel_n(sel_n), .coin_valid(coin_valid),
    .coin_val(coin_val), .cancel(cancel), .selected(selected),
    .credit(credit), .cost(cost), .change(change),
    .change_valid(change_valid), .serving(serving),
    .time_left(time_left), .done(done), .coin_reject(coin_reject),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_coin(input logic [AW-1:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    cyc(1);
    coin_valid = 1'b0;
    coin_val   = '0;
  endtask

  task automatic do_press(input logic [ND-1:0] pat);
    sel_n = pat;
    cyc(3);
    sel_n = '1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
    int k = 0;
    while (state_o !== s && k < limit) begin
      cyc(1);
      k++;
    end
    check(tag, state_o, s);
  endtask

  // Follow a SERVE phase from its first cycle through DONE back to IDLE
  task automatic run_serve(input int secs, input string tag);
    int cnt = 0;
    while (serving === 1'b1 && cnt < 200) begin
      check({tag, "_time_left"}, time_left, secs - cnt / TPS);
      cnt++;
      cyc(1);
    end
    check({tag, "_serve_len"}, cnt, secs * TPS);
    check({tag, "_done"}, done, 1);
    check({tag, "_state_done"}, state_o, 3);
    check({tag, "_tl_zero"}, time_left, 0);
    check({tag, "_sel_clr"}, selected, 0);
    cyc(1);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, state_o, 0);
  endtask

  // Scoreboard: every change_valid pulse consumes one queued expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && change_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL change_unexpected: observed %0d expected no pulse", change);
      end else begin
        check("change", change, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel_n = '1; coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
    #2 rst = 1'b0;
    cyc(2);
    check("reset_data", {selected, credit, cost, change}, 0);
    check("reset_ctrl", {change_valid, serving, time_left, done, coin_reject, state_o}, 0);
    rst = 1'b1;
    cyc(2);

    // Drink 2 (cost 2), exact payment, 5 s serve
    sel_n = 4'b1011;
    cyc(2);
    check("press_latency", selected, 0);
    cyc(1);
    check("sel_d2", selected, 4'b0100);
    check("cost_d2", cost, 2);
    check("state_pay", state_o, 1);
    sel_n = '1;
    exp_q.push_back(0);
    put_coin(8'd2);
    check("credit_2", credit, 2);
    check("still_pay", state_o, 1);
    cyc(1);
    check("serve_d2", state_o, 2);
    check("serving_d2", serving, 1);
    run_serve(5, "d2");

    // Drink 0 (cost 4), coins 3+3, change 2, 8 s serve
    do_press(4'b1110);
    check("cost_d0", cost, 4);
    put_coin(8'd3);
    check("credit_3", credit, 3);
    exp_q.push_back(2);
    put_coin(8'd3);
    check("credit_6", credit, 6);
    cyc(1);
    check("serve_d0", state_o, 2);
    run_serve(8, "d0");

    // Simultaneous presses on 1 and 3: lowest index wins; then cancel with no credit
    do_press(4'b0101);
    check("sel_multi", selected, 4'b0010);
    check("cost_multi", cost, 3);
    exp_q.push_back(0);
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
    check("refund0_state", state_o, 4);
    check("refund0_sel", selected, 0);
    cyc(1);
    check("refund0_idle", state_o, 0);

    // Drink 1, coin 1, cancel -> refund 1
    do_press(4'b1101);
    put_coin(8'd1);
    check("credit_1", credit, 1);
    exp_q.push_back(1);
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
    check("refund1_state", state_o, 4);
    check("refund1_credit", credit, 0);
    check("refund1_cost", cost, 0);
    check("refund1_noserve", serving, 0);
    cyc(1);
    check("refund1_idle", state_o, 0);

    // Cancel and coin in the same cycle: the coin joins the refund
    do_press(4'b1101);
    put_coin(8'd1);
    exp_q.push_back(2);
    cancel = 1'b1; coin_valid = 1'b1; coin_val = 8'd1;
    cyc(1);
    cancel = 1'b0; coin_valid = 1'b0; coin_val = '0;
    check("cancel_coin_noreject", coin_reject, 0);
    check("cancel_coin_state", state_o, 4);
    cyc(1);

    // Coin in IDLE is rejected
    put_coin(8'd5);
    check("idle_reject", coin_reject, 1);
    check("idle_credit", credit, 0);
    check("idle_state", state_o, 0);
    cyc(1);
    check("reject_pulse", coin_reject, 0);

    // Saturation: 200 then 200 on the payment cycle -> credit 255, change 251
    do_press(4'b1110);
    exp_q.push_back(251);
    coin_valid = 1'b1; coin_val = 8'd200;
    cyc(1);
    check("credit_200", credit, 200);
    cyc(1);
    coin_valid = 1'b0; coin_val = '0;
    check("credit_sat", credit, 255);
    check("sat_serve", state_o, 2);
    put_coin(8'd7);
    check("serve_reject", coin_reject, 1);
    check("serve_credit", credit, 255);
    wait_state(3'd0, 100, "sat_back_idle");

    // PAY inactivity
    do_press(4'b1110);
`ifdef VEND_TIMEOUT_EN
    exp_q.push_back(1);
    put_coin(8'd1);
    begin
      int k = 0;
      while (change_valid !== 1'b1 && k < 100) begin
        cyc(1);
        k++;
      end
      check("timeout_cycles", k, 40);
      check("timeout_state", state_o, 4);
    end
    cyc(1);
    check("timeout_idle", state_o, 0);
`else
    put_coin(8'd1);
    cyc(60);
    check("no_timeout_state", state_o, 1);
    check("no_timeout_credit", credit, 1);
    exp_q.push_back(1);
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
    check("late_cancel", state_o, 4);
    cyc(1);
`endif

    // Asynchronous reset while serving clears everything
    do_press(4'b0111);
    exp_q.push_back(0);
    put_coin(8'd1);
    cyc(1);
    check("rst_serve_serving", serving, 1);
    cyc(3);
    #2 rst = 1'b0;
    #1;
    check("midrst_data", {selected, credit, cost, change}, 0);
    check("midrst_ctrl", {change_valid, serving, time_left, done, coin_reject, state_o}, 0);
    cyc(1);
    rst = 1'b1;
    cyc(2);
    check("after_rst_idle", state_o, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
